// File: rtl/mix_pkg.sv
// mix_pkg: shared state encoding, FIN lane coefficients and counter width for the mix engine
package mix_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [2:0] {IDLE, PRE, MIX, FIN, DONE} state_t;
  function automatic int lane_mul(input int i);
    return 2 * i + 3;
  endfunction
  function automatic int lane_add(input int i);
    return i * i;
  endfunction
endpackage

// File: rtl/mix_round_chain.sv
// mix_round_chain: combinational PRE/MIX lane chain where each lane sees already-updated lower lanes
module mix_round_chain
  import mix_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int LANES = 8
) (
  input  state_t                   mode_i,
  input  logic [LANES*WIDTH-1:0]   data_i,
  output logic [LANES*WIDTH-1:0]   data_o
);
  // In-place update inside the function models the ripple through the lanes
  function automatic logic [LANES*WIDTH-1:0] chain(input logic [LANES*WIDTH-1:0] v, input logic pre);
    logic [WIDTH-1:0] o [LANES];
    logic [LANES*WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++) o[i] = v[i*WIDTH +: WIDTH] + (pre ? WIDTH'(i) : '0);
    for (int i = 0; i < LANES; i++)
      o[i] = pre ? o[i] + o[(i+LANES-1)%LANES]
                 : o[i] + o[(i+LANES-1)%LANES] - o[(i+LANES-2)%LANES];
    for (int i = 0; i < LANES; i++) r[i*WIDTH +: WIDTH] = o[i];
    return r;
  endfunction
  assign data_o = chain(data_i, mode_i == PRE);
endmodule

// File: rtl/mix_engine_param.sv
// mix_engine_param: handshaked PRE / ROUNDS x MIX / FIN lane-mixing engine with held result
module mix_engine_param
  import mix_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int LANES  = 8,
  parameter int ROUNDS = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   busy
);
  state_t state_q, state_d;
  logic [LANES*WIDTH-1:0] data_q, data_d, chain_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  function automatic logic [LANES*WIDTH-1:0] fin(input logic [LANES*WIDTH-1:0] v);
    logic [LANES*WIDTH-1:0] r;
    for (int i = 0; i < LANES; i++)
      r[i*WIDTH +: WIDTH] = v[i*WIDTH +: WIDTH] * WIDTH'(lane_mul(i)) + WIDTH'(lane_add(i));
    return r;
  endfunction
  mix_round_chain #(.WIDTH(WIDTH), .LANES(LANES)) u_chain (
    .mode_i(state_q),
    .data_i(data_q),
    .data_o(chain_w)
  );
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        data_d  = in_data;
        state_d = PRE;
      end
      PRE: begin
        data_d  = chain_w;
        cnt_d   = '0;
        state_d = ROUNDS == 0 ? FIN : MIX;
      end
      MIX: begin
        data_d  = chain_w;
        cnt_d   = cnt_q + 1'b1;
        state_d = cnt_q == CNT_W'(ROUNDS - 1) ? FIN : MIX;
      end
      FIN: begin
        data_d  = fin(data_q);
        state_d = DONE;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q inside {PRE, MIX, FIN};
  assign out_data  = out_valid ? data_q : '0;
endmodule

// File: tb/tb_mix_engine_param.sv
// tb_mix_engine_param: randomized checks of three engine configurations against an arithmetic model
module tb_mix_engine_param;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0, a_busy;
  logic [255:0] a_in_data = '0, a_out_data;
  logic b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0, b_busy;
  logic [15:0] b_in_data = '0, b_out_data;
  logic c_in_valid = 0, c_in_ready, c_out_valid, c_out_ready = 0, c_busy;
  logic [31:0] c_in_data = '0, c_out_data;
  int checks = 0, errors = 0, n_out = 0;
  logic [255:0] exp_q [$];

  mix_engine_param #(.WIDTH(32), .LANES(8), .ROUNDS(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .busy(a_busy));
  mix_engine_param #(.WIDTH(8), .LANES(2), .ROUNDS(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .busy(b_busy));
  mix_engine_param #(.WIDTH(8), .LANES(4), .ROUNDS(3)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .busy(c_busy));

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] model(input logic [255:0] seed, input int w, input int l, input int r);
    longint unsigned o [64];
    longint unsigned m = (64'd1 << w) - 1;
    logic [255:0] res = '0;
    for (int i = 0; i < l; i++) o[i] = (64'(seed >> (i * w)) + longint'(i)) & m;
    for (int i = 0; i < l; i++) o[i] = (o[i] + o[(i + l - 1) % l]) & m;
    for (int k = 0; k < r; k++)
      for (int i = 0; i < l; i++) o[i] = (o[i] + o[(i + l - 1) % l] - o[(i + l - 2) % l]) & m;
    for (int i = 0; i < l; i++) o[i] = (o[i] * longint'(2 * i + 3) + longint'(i * i)) & m;
    for (int i = 0; i < l; i++) res |= 256'(o[i]) << (i * w);
    return res;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Scoreboard for the 8-lane engine: handshakes are judged at the negedge before the edge that takes them
  always @(negedge clk) begin
    if (rst) exp_q.delete();
    else begin
      if (a_in_valid && a_in_ready) exp_q.push_back(model(a_in_data, 32, 8, 16));
      if (a_out_valid && a_out_ready) begin
        n_out++;
        if (exp_q.size() > 0) check("a_result", a_out_data, exp_q.pop_front());
        else check("a_orphan", 256'(exp_q.size()), 256'(1));
      end
    end
  end

  task automatic a_send(input logic [255:0] seed);
    int n = 0;
    a_in_data = seed;
    a_in_valid = 1;
    while (!a_in_ready && n < 200) begin @(posedge clk); #1; n++; end
    check("a_accept_tmo", n < 200, 1);
    @(posedge clk); #1;
    a_in_valid = 0;
  endtask

  // Latency = rising edges after the accept edge up to the first one that sees out_valid high
  task automatic a_wait(output int lat);
    lat = 1;
    while (!a_out_valid && lat < 300) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic a_pop();
    a_out_ready = 1;
    @(posedge clk); #1;
    a_out_ready = 0;
  endtask

  task automatic s_job(input int sel, input logic [31:0] seed, output logic [31:0] res, output int lat);
    check("s_ready", sel == 0 ? b_in_ready : c_in_ready, 1);
    if (sel == 0) begin b_in_data = seed[15:0]; b_in_valid = 1; end
    else begin c_in_data = seed; c_in_valid = 1; end
    @(posedge clk); #1;
    b_in_valid = 0;
    c_in_valid = 0;
    lat = 1;
    while (!(sel == 0 ? b_out_valid : c_out_valid) && lat < 300) begin @(posedge clk); #1; lat++; end
    res = sel == 0 ? {16'h0, b_out_data} : c_out_data;
    b_out_ready = sel == 0;
    c_out_ready = sel != 0;
    @(posedge clk); #1;
    b_out_ready = 0;
    c_out_ready = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    logic [255:0] seed, snap;
    logic [31:0] res;
    int lat, base, n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", a_in_ready, 1);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_busy", a_busy, 0);
    check("rst_out_data", a_out_data, 0);
    rst = 0;
    @(posedge clk); #1;
    check("idle_in_ready", a_in_ready, 1);

    s_job(0, 32'h0, res, lat);
    check("t1_lat", lat, 3);
    check("t1_data", res, 32'h0000_0B03);
    check("t1_model", res, model(256'h0, 8, 2, 0));
    for (int k = 0; k < 3; k++) begin
      seed = {224'h0, 16'($urandom)};
      s_job(0, seed[31:0], res, lat);
      check("t1_rand", res, model(seed, 8, 2, 0));
    end

    s_job(1, 32'hFFFF_FFFF, res, lat);
    check("t6_lat", lat, 6);
    check("t6_wrap", res, model(256'hFFFF_FFFF, 8, 4, 3));
    seed = {224'h0, 32'($urandom)};
    s_job(1, seed[31:0], res, lat);
    check("t6_rand", res, model(seed, 8, 4, 3));

    for (int i = 0; i < 8; i++) seed[i*32 +: 32] = i;
    a_send(seed);
    a_wait(lat);
    check("t2_lat", lat, 19);
    check("t2_data", a_out_data, model(seed, 32, 8, 16));
    a_pop();

    seed = rnd256();
    a_send(seed);
    a_wait(lat);
    snap = a_out_data;
    check("t3_data", snap, model(seed, 32, 8, 16));
    a_in_data = rnd256();
    a_in_valid = 1;
    repeat (10) begin
      @(posedge clk); #1;
      check("t3_stable", a_out_data, snap);
      check("t3_valid", a_out_valid, 1);
      check("t3_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1;
    @(posedge clk); #1;
    a_out_ready = 0;
    check("t3_idle_ready", a_in_ready, 1);
    check("t3_not_taken", a_busy, 0);
    @(posedge clk); #1;
    a_in_valid = 0;
    check("t3_taken", a_busy, 1);
    a_wait(lat);
    check("t3_lat", lat, 19);
    a_pop();

    a_send(rnd256());
    repeat (6) @(posedge clk);
    #1;
    check("t4_mid_busy", a_busy, 1);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("t4_in_ready", a_in_ready, 1);
    check("t4_out_valid", a_out_valid, 0);
    check("t4_busy", a_busy, 0);
    check("t4_out_data", a_out_data, 0);
    seed = rnd256();
    a_send(seed);
    a_wait(lat);
    check("t4_lat", lat, 19);
    check("t4_data", a_out_data, model(seed, 32, 8, 16));
    a_pop();

    base = n_out;
    a_out_ready = 1;
    a_in_valid = 1;
    for (int k = 0; k < 20; k++) begin
      a_in_data = rnd256();
      n = 0;
      while (!a_in_ready && n < 200) begin @(posedge clk); #1; n++; end
      check("t5_accept_tmo", n < 200, 1);
      @(posedge clk); #1;
    end
    a_in_valid = 0;
    n = 0;
    while (n_out - base < 20 && n < 2000) begin @(posedge clk); #1; n++; end
    check("t5_count", n_out - base, 20);
    check("t5_queue", exp_q.size(), 0);
    a_out_ready = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
